// File: rtl/loopback_test_pkg.sv
// Shared types for the DAC->ADC loopback test sequencer: FSM states, mode/pattern
// encodings and the expected-response function of an ideal inverting loopback.
package loopback_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PWR_UP,
        ST_DRIVE,
        ST_WAIT_RSP,
        ST_NEXT,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        MODE_SINGLE  = 2'b00,
        MODE_MULTI   = 2'b01,
        MODE_FREE    = 2'b10,
        MODE_ILLEGAL = 2'b11
    } test_mode_e;

    typedef enum logic [1:0] {
        PAT_ALT     = 2'b00,
        PAT_WALK    = 2'b01,
        PAT_INC     = 2'b10,
        PAT_CHECKER = 2'b11
    } pattern_e;

    // Widest sample the response function handles; callers mask down to DATA_W.
    localparam int RSP_MAX_W = 64;

    function automatic logic [RSP_MAX_W-1:0] expected_rsp(input logic [RSP_MAX_W-1:0] stim);
        return ~stim;
    endfunction

endpackage

// File: rtl/loopback_pattern_gen.sv
// Combinational stimulus word generator: alternating, walking-one, incrementing
// and checkerboard patterns indexed by pass count and channel.
module loopback_pattern_gen
    import loopback_test_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int CH_W   = 2
) (
    input  logic [1:0]        pattern_sel,
    input  logic [31:0]       cycle_count,
    input  logic [CH_W-1:0]   ch,
    output logic [DATA_W-1:0] word
);

    logic [DATA_W-1:0] alt;

    always_comb begin
        alt = '0;
        for (int i = 1; i < DATA_W; i += 2) alt[i] = 1'b1;
    end

    always_comb begin
        word = '0;
        case (pattern_e'(pattern_sel))
            PAT_ALT:     word = alt;
            PAT_WALK:    word = DATA_W'(1) << (cycle_count % 32'(DATA_W));
            PAT_INC:     word = DATA_W'(cycle_count) + DATA_W'(ch);
            PAT_CHECKER: word = alt ^ {DATA_W{cycle_count[0]}};
            default:     word = alt;
        endcase
    end

endmodule

// File: rtl/loopback_test_seq.sv
// DAC->ADC loopback test sequencer: powers the DUT, scans enabled channels, checks
// inverted responses, keeps saturating stats. LOOPBACK_PER_CH_ERR_EN adds ch_err_count.
//
// state    | meaning
// IDLE     | power off, waiting for an acceptable start
// PWR_UP   | power_en held for PWR_DLY cycles before first stimulus
// DRIVE    | one-cycle dac_valid strobe on the current channel
// WAIT_RSP | waiting for adc_ready or the response timeout
// NEXT     | step to next enabled channel, count pass on wrap
// DONE     | one cycle; test_done raised, then back to IDLE
module loopback_test_seq
    import loopback_test_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int NUM_CH  = 4,
    parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int CNT_W   = 16,
    parameter int TO_W    = 16,
    parameter int PWR_DLY = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [1:0]          test_mode,
    input  logic [1:0]          pattern_sel,
    input  logic [NUM_CH-1:0]   ch_mask,
    input  logic [31:0]         max_cycles,
    input  logic [TO_W-1:0]     timeout_cycles,
    input  logic [DATA_W-1:0]   adc_data,
    input  logic                adc_ready,
    output logic [DATA_W-1:0]   dac_cmd,
    output logic [CH_W-1:0]     dac_ch,
    output logic                dac_valid,
    output logic                power_en,
    output logic                busy,
    output logic                test_done,
    output logic                fail,
    output logic [CNT_W-1:0]    error_count,
    output logic [CNT_W-1:0]    timeout_count,
    output logic [31:0]         cycle_count
`ifdef LOOPBACK_PER_CH_ERR_EN
    ,
    output logic [NUM_CH*CNT_W-1:0] ch_err_count
`endif
);

    localparam int PD_W = $clog2(PWR_DLY + 1);
    localparam logic [RSP_MAX_W-1:0] DATA_MASK = {RSP_MAX_W{1'b1}} >> (RSP_MAX_W - DATA_W);

    function automatic logic [CH_W-1:0] lowest_ch(input logic [NUM_CH-1:0] mask);
        logic [CH_W-1:0] low = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) low = CH_W'(i);
        end
        return low;
    endfunction

    // Returns {wrap, channel}: nearest enabled channel above cur, else the lowest one.
    function automatic logic [CH_W:0] pick_next(input logic [NUM_CH-1:0] mask,
                                                input logic [CH_W-1:0]   cur);
        logic [CH_W-1:0] above = '0;
        logic            found = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (CH_W'(i) > cur)) begin
                above = CH_W'(i);
                found = 1'b1;
            end
        end
        return found ? {1'b0, above} : {1'b1, lowest_ch(mask)};
    endfunction

    state_e            state_q, state_d;
    test_mode_e        mode_q;
    logic [1:0]        sel_q;
    logic [NUM_CH-1:0] mask_q;
    logic [31:0]       max_q;
    logic [TO_W-1:0]   to_q;
    logic [TO_W-1:0]   to_cnt;
    logic [PD_W-1:0]   pwr_cnt;
    logic [CH_W-1:0]   cur_ch;
    logic [DATA_W-1:0] cmd_q;
    logic [DATA_W-1:0] pat_word;

    logic              start_ok, accept, cnt_mis, cnt_to, advance, slot_err;
    logic              next_wrap, rsp_mismatch, to_fire, finish;
    logic [CH_W-1:0]   next_ch;
    logic [31:0]       new_cc;

    loopback_pattern_gen #(
        .DATA_W (DATA_W),
        .CH_W   (CH_W)
    ) u_pattern_gen (
        .pattern_sel (sel_q),
        .cycle_count (cycle_count),
        .ch          (cur_ch),
        .word        (pat_word)
    );

    assign start_ok     = (test_mode != MODE_ILLEGAL) && (ch_mask != '0);
    assign {next_wrap, next_ch} = pick_next(mask_q, cur_ch);
    assign new_cc       = (cycle_count == '1) ? cycle_count : cycle_count + 32'd1;
    assign finish       = next_wrap && ((mode_q == MODE_SINGLE) ||
                                        ((mode_q == MODE_MULTI) && (new_cc == max_q)));
    assign to_fire      = (to_q != '0) && (to_cnt == TO_W'(1));
    assign rsp_mismatch = ((expected_rsp(RSP_MAX_W'(cmd_q)) ^ RSP_MAX_W'(adc_data))
                           & DATA_MASK) != '0;
    assign slot_err     = cnt_mis || cnt_to;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        cnt_mis = 1'b0;
        cnt_to  = 1'b0;
        advance = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && start_ok) begin
                    accept  = 1'b1;
                    state_d = ST_PWR_UP;
                end
            end
            ST_PWR_UP: begin
                if (abort)                                        state_d = ST_DONE;
                else if ((mode_q == MODE_MULTI) && (max_q == '0)) state_d = ST_DONE;
                else if (pwr_cnt == '0)                           state_d = ST_DRIVE;
            end
            ST_DRIVE: state_d = abort ? ST_DONE : ST_WAIT_RSP;
            ST_WAIT_RSP: begin
                if (abort) begin
                    state_d = ST_DONE;
                end else if (adc_ready) begin
                    cnt_mis = rsp_mismatch;
                    state_d = ST_NEXT;
                end else if (to_fire) begin
                    cnt_to  = 1'b1;
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (abort) begin
                    state_d = ST_DONE;
                end else begin
                    advance = 1'b1;
                    state_d = finish ? ST_DONE : ST_DRIVE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q        <= MODE_SINGLE;
            sel_q         <= '0;
            mask_q        <= '0;
            max_q         <= '0;
            to_q          <= '0;
            to_cnt        <= '0;
            pwr_cnt       <= '0;
            cur_ch        <= '0;
            cmd_q         <= '0;
            test_done     <= 1'b0;
            fail          <= 1'b0;
            error_count   <= '0;
            timeout_count <= '0;
            cycle_count   <= '0;
        end else begin
            if (accept) begin
                mode_q        <= test_mode_e'(test_mode);
                sel_q         <= pattern_sel;
                mask_q        <= ch_mask;
                max_q         <= max_cycles;
                to_q          <= timeout_cycles;
                pwr_cnt       <= PD_W'(PWR_DLY - 1);
                cur_ch        <= lowest_ch(ch_mask);
                test_done     <= 1'b0;
                fail          <= 1'b0;
                error_count   <= '0;
                timeout_count <= '0;
                cycle_count   <= '0;
            end
            if ((state_q == ST_PWR_UP) && (pwr_cnt != '0)) pwr_cnt <= pwr_cnt - PD_W'(1);
            if (state_q == ST_DRIVE) begin
                cmd_q  <= pat_word;
                to_cnt <= to_q;
            end
            if ((state_q == ST_WAIT_RSP) && (to_cnt != '0)) to_cnt <= to_cnt - TO_W'(1);
            if (slot_err) begin
                fail <= 1'b1;
                if (error_count != '1) error_count <= error_count + CNT_W'(1);
            end
            if (cnt_to && (timeout_count != '1)) timeout_count <= timeout_count + CNT_W'(1);
            if (advance) begin
                cur_ch <= next_ch;
                if (next_wrap) cycle_count <= new_cc;
            end
            if (state_d == ST_DONE) test_done <= 1'b1;
        end
    end

`ifdef LOOPBACK_PER_CH_ERR_EN
    logic [NUM_CH-1:0][CNT_W-1:0] ch_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                  ch_err <= '0;
        else if (accept)                             ch_err <= '0;
        else if (slot_err && (ch_err[cur_ch] != '1)) ch_err[cur_ch] <= ch_err[cur_ch] + CNT_W'(1);
    end

    assign ch_err_count = ch_err;
`endif

    assign busy      = (state_q != ST_IDLE);
    assign power_en  = (state_q != ST_IDLE);
    assign dac_valid = (state_q == ST_DRIVE);
    assign dac_cmd   = (state_q == ST_DRIVE) ? pat_word : cmd_q;
    assign dac_ch    = cur_ch;

endmodule

// File: tb/tb_loopback_test_seq.sv
// Scoreboard bench for loopback_test_seq: directed tests push expected DAC strobes,
// a monitor pops and compares them; a loopback model answers on adc_data/adc_ready.
module tb_loopback_test_seq;

    localparam int DATA_W  = 16;
    localparam int NUM_CH  = 4;
    localparam int CH_W    = 2;
    localparam int CNT_W   = 4;
    localparam int TO_W    = 16;
    localparam int PWR_DLY = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort_main = 1'b0;
    logic              rsp_abort = 1'b0;
    logic              abort_w;
    logic [1:0]        test_mode = '0;
    logic [1:0]        pattern_sel = '0;
    logic [NUM_CH-1:0] ch_mask = '0;
    logic [31:0]       max_cycles = '0;
    logic [TO_W-1:0]   timeout_cycles = '0;
    logic [DATA_W-1:0] adc_data = '0;
    logic              adc_ready = 1'b0;

    logic [DATA_W-1:0] dac_cmd;
    logic [CH_W-1:0]   dac_ch;
    logic              dac_valid, power_en, busy, test_done, fail;
    logic [CNT_W-1:0]  error_count, timeout_count;
    logic [31:0]       cycle_count;
`ifdef LOOPBACK_PER_CH_ERR_EN
    logic [NUM_CH*CNT_W-1:0] ch_err_count;
`endif

    assign abort_w = abort_main | rsp_abort;

    loopback_test_seq #(
        .DATA_W (DATA_W), .NUM_CH (NUM_CH), .CH_W (CH_W), .CNT_W (CNT_W),
        .TO_W (TO_W), .PWR_DLY (PWR_DLY)
    ) dut (
        .clk (clk), .rst_n (rst_n), .start (start), .abort (abort_w),
        .test_mode (test_mode), .pattern_sel (pattern_sel), .ch_mask (ch_mask),
        .max_cycles (max_cycles), .timeout_cycles (timeout_cycles),
        .adc_data (adc_data), .adc_ready (adc_ready),
        .dac_cmd (dac_cmd), .dac_ch (dac_ch), .dac_valid (dac_valid),
        .power_en (power_en), .busy (busy), .test_done (test_done), .fail (fail),
        .error_count (error_count), .timeout_count (timeout_count),
        .cycle_count (cycle_count)
`ifdef LOOPBACK_PER_CH_ERR_EN
        , .ch_err_count (ch_err_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CH_W-1:0]   ch;
        logic [DATA_W-1:0] cmd;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    bit   resp_en = 1'b1;
    bit   fault_all = 1'b0;
    bit   abort_with_rsp = 1'b0;
    int   fault_ch = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [CH_W-1:0] ch, input logic [DATA_W-1:0] cmd);
        exp_t e;
        e.ch  = ch;
        e.cmd = cmd;
        sb_q.push_back(e);
    endtask

    task automatic do_start(input logic [1:0] mode, input logic [1:0] sel,
                            input logic [NUM_CH-1:0] mask, input logic [31:0] maxc,
                            input logic [TO_W-1:0] to);
        @(posedge clk); #1;
        test_mode      = mode;
        pattern_sel    = sel;
        ch_mask        = mask;
        max_cycles     = maxc;
        timeout_cycles = to;
        start          = 1'b1;
        @(posedge clk); #1;
        start          = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (test_done !== 1'b1 && n < budget);
        n_vec++;
        if (test_done !== 1'b1) begin
            n_err++;
            $display("FAIL %s_done: test_done not seen within %0d cycles", name, budget);
            @(posedge clk); #1 abort_main = 1'b1;
            @(posedge clk); #1 abort_main = 1'b0;
        end
    endtask

    task automatic wait_valid(input string name, output int at);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (dac_valid !== 1'b1 && n < 200);
        at = cyc;
        n_vec++;
        if (dac_valid !== 1'b1) begin
            n_err++;
            $display("FAIL %s_strobe: dac_valid not seen within 200 cycles", name);
        end
    endtask

    task automatic end_test(input string name);
        repeat (4) @(negedge clk);
        check({name, "_busy_end"}, 32'(busy), 0);
        check({name, "_power_end"}, 32'(power_en), 0);
        check({name, "_queue_left"}, 32'(sb_q.size()), 0);
        sb_q.delete();
    endtask

    // Monitor: every DAC strobe must match the head of the expected queue.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (dac_valid === 1'b1) begin
                n_vec++;
                if (sb_q.size() == 0) begin
                    n_err++;
                    $display("FAIL strobe_unexpected: got ch=%0d cmd=0x%h, expected none", dac_ch, dac_cmd);
                end else begin
                    e = sb_q.pop_front();
                    if (dac_ch !== e.ch || dac_cmd !== e.cmd) begin
                        n_err++;
                        $display("FAIL strobe: got ch=%0d cmd=0x%h, expected ch=%0d cmd=0x%h",
                                 dac_ch, dac_cmd, e.ch, e.cmd);
                    end
                end
            end
        end
    end

    // Loopback model: answers two cycles after each strobe with the inverted word.
    initial begin : responder
        logic [DATA_W-1:0] cmd;
        logic [CH_W-1:0]   ch;
        forever begin
            @(negedge clk);
            if (dac_valid === 1'b1 && resp_en) begin
                cmd = dac_cmd;
                ch  = dac_ch;
                @(posedge clk);
                @(posedge clk); #1;
                adc_data  = (fault_all || int'(ch) == fault_ch) ? 16'h5554 : ~cmd;
                adc_ready = 1'b1;
                if (abort_with_rsp) rsp_abort = 1'b1;
                @(posedge clk); #1;
                adc_ready = 1'b0;
                rsp_abort = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #400000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : main
        int lat;
        int t0, t1, t2;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_power_en", 32'(power_en), 0);
        check("rst_dac_valid", 32'(dac_valid), 0);
        check("rst_dac_cmd", 32'(dac_cmd), 0);
        check("rst_dac_ch", 32'(dac_ch), 0);
        check("rst_test_done", 32'(test_done), 0);
        check("rst_fail", 32'(fail), 0);
        check("rst_error_count", 32'(error_count), 0);
        check("rst_timeout_count", 32'(timeout_count), 0);
        check("rst_cycle_count", cycle_count, 0);

        // Single pass, mask 0101, alternating pattern, ideal loopback.
        push_exp(2'd0, 16'hAAAA);
        push_exp(2'd2, 16'hAAAA);
        do_start(2'b00, 2'b00, 4'b0101, 32'd0, 16'd0);
        lat = 1;
        @(negedge clk);
        check("t1_busy_after_start", 32'(busy), 1);
        check("t1_power_after_start", 32'(power_en), 1);
        while (dac_valid !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("t1_first_strobe_latency", lat, PWR_DLY + 1);
        wait_done("t1", 100);
        check("t1_error_count", 32'(error_count), 0);
        check("t1_cycle_count", cycle_count, 1);
        check("t1_test_done", 32'(test_done), 1);
        check("t1_fail", 32'(fail), 0);
        end_test("t1");

        // Start while busy and config changes mid-run are ignored.
        push_exp(2'd2, 16'hAAAA);
        do_start(2'b00, 2'b00, 4'b0100, 32'd0, 16'd0);
        @(posedge clk); #1;
        test_mode   = 2'b10;
        pattern_sel = 2'b01;
        ch_mask     = 4'b1111;
        start       = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done("t_busy_start", 100);
        check("t_busy_start_cycle_count", cycle_count, 1);
        end_test("t_busy_start");

        // Mode 01, three passes, all channels, walking-one.
        for (int p = 0; p < 3; p++)
            for (int c = 0; c < 4; c++) push_exp(2'(c), 16'(1) << p);
        do_start(2'b01, 2'b01, 4'b1111, 32'd3, 16'd0);
        wait_done("t2", 300);
        check("t2_cycle_count", cycle_count, 3);
        check("t2_error_count", 32'(error_count), 0);
        end_test("t2");

        // Fault on channel 1.
        fault_ch = 1;
        for (int c = 0; c < 4; c++) push_exp(2'(c), 16'hAAAA);
        do_start(2'b00, 2'b00, 4'b1111, 32'd0, 16'd0);
        wait_done("t3", 200);
        check("t3_error_count", 32'(error_count), 1);
        check("t3_fail", 32'(fail), 1);
        check("t3_timeout_count", 32'(timeout_count), 0);
`ifdef LOOPBACK_PER_CH_ERR_EN
        check("t3_ch_err_count", 32'(ch_err_count), 32'h0010);
`endif
        fault_ch = -1;
        end_test("t3");

        // Incrementing pattern, mask 1010, two passes; fail cleared by start.
        push_exp(2'd1, 16'h0001);
        push_exp(2'd3, 16'h0003);
        push_exp(2'd1, 16'h0002);
        push_exp(2'd3, 16'h0004);
        do_start(2'b01, 2'b10, 4'b1010, 32'd2, 16'd0);
        @(negedge clk);
        check("t4_fail_cleared", 32'(fail), 0);
        wait_done("t4", 200);
        check("t4_cycle_count", cycle_count, 2);
        check("t4_error_count", 32'(error_count), 0);
        end_test("t4");

        // Checkerboard flips on odd passes.
        push_exp(2'd0, 16'hAAAA);
        push_exp(2'd0, 16'h5555);
        do_start(2'b01, 2'b11, 4'b0001, 32'd2, 16'd0);
        wait_done("t5", 200);
        check("t5_cycle_count", cycle_count, 2);
        end_test("t5");

        // Timeout of 5 wait cycles with no responses.
        resp_en = 1'b0;
        push_exp(2'd0, 16'hAAAA);
        push_exp(2'd1, 16'hAAAA);
        do_start(2'b00, 2'b00, 4'b0011, 32'd0, 16'd5);
        wait_valid("t6a", t0);
        wait_valid("t6b", t1);
        check("t6_slot_gap", t1 - t0, 7);
        wait_done("t6", 100);
        check("t6_timeout_count", 32'(timeout_count), 2);
        check("t6_error_count", 32'(error_count), 2);
        check("t6_fail", 32'(fail), 1);
`ifdef LOOPBACK_PER_CH_ERR_EN
        check("t6_ch_err_count", 32'(ch_err_count), 32'h0011);
`endif
        end_test("t6");

        // timeout_cycles=0 waits forever until abort.
        push_exp(2'd0, 16'hAAAA);
        do_start(2'b00, 2'b00, 4'b0001, 32'd0, 16'd0);
        repeat (40) @(negedge clk);
        check("t7_busy_hang", 32'(busy), 1);
        check("t7_done_hang", 32'(test_done), 0);
        check("t7_timeout_hang", 32'(timeout_count), 0);
        @(posedge clk); #1 abort_main = 1'b1;
        @(posedge clk); #1 abort_main = 1'b0;
        @(negedge clk);
        check("t7_done_after_abort", 32'(test_done), 1);
        end_test("t7");
        resp_en = 1'b1;

        // Illegal mode and empty mask are ignored; test_done is retained.
        do_start(2'b11, 2'b00, 4'b0001, 32'd0, 16'd0);
        @(negedge clk);
        check("t8_busy_illegal_mode", 32'(busy), 0);
        check("t8_done_kept", 32'(test_done), 1);
        do_start(2'b00, 2'b00, 4'b0000, 32'd0, 16'd0);
        @(negedge clk);
        check("t8_busy_empty_mask", 32'(busy), 0);
        end_test("t8");

        // 20 faulty slots saturate the 4-bit error counter.
        fault_all = 1'b1;
        for (int p = 0; p < 5; p++)
            for (int c = 0; c < 4; c++) push_exp(2'(c), 16'hAAAA);
        do_start(2'b01, 2'b00, 4'b1111, 32'd5, 16'd0);
        wait_done("t9", 400);
        check("t9_error_sat", 32'(error_count), 15);
        check("t9_cycle_count", cycle_count, 5);
`ifdef LOOPBACK_PER_CH_ERR_EN
        check("t9_ch_err_count", 32'(ch_err_count), 32'h5555);
`endif
        end_test("t9");

        // Abort coincident with a faulty response: nothing counted.
        abort_with_rsp = 1'b1;
        push_exp(2'd0, 16'hAAAA);
        do_start(2'b00, 2'b00, 4'b0011, 32'd0, 16'd0);
        wait_done("t10", 100);
        check("t10_error_count", 32'(error_count), 0);
        check("t10_fail", 32'(fail), 0);
        check("t10_cycle_count", cycle_count, 0);
        abort_with_rsp = 1'b0;
        fault_all      = 1'b0;
        end_test("t10");

        // Free-run walking-one, aborted during the third wait.
        push_exp(2'd0, 16'h0001);
        push_exp(2'd0, 16'h0002);
        push_exp(2'd0, 16'h0004);
        do_start(2'b10, 2'b01, 4'b0001, 32'd0, 16'd0);
        wait_valid("t11a", t0);
        wait_valid("t11b", t1);
        wait_valid("t11c", t2);
        @(posedge clk); #1 abort_main = 1'b1;
        @(posedge clk); #1 abort_main = 1'b0;
        wait_done("t11", 20);
        check("t11_cycle_count", cycle_count, 2);
        check("t11_error_count", 32'(error_count), 0);
        end_test("t11");

        // Asynchronous reset while waiting for a response.
        resp_en = 1'b0;
        push_exp(2'd2, 16'hAAAA);
        do_start(2'b00, 2'b00, 4'b0100, 32'd0, 16'd0);
        wait_valid("t12", t0);
        repeat (3) @(negedge clk);
        check("t12_pre_dac_ch", 32'(dac_ch), 2);
        check("t12_pre_power", 32'(power_en), 1);
        #2 rst_n = 1'b0;
        #1;
        check("t12_rst_power", 32'(power_en), 0);
        check("t12_rst_busy", 32'(busy), 0);
        check("t12_rst_dac_cmd", 32'(dac_cmd), 0);
        check("t12_rst_dac_ch", 32'(dac_ch), 0);
        check("t12_rst_test_done", 32'(test_done), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        resp_en = 1'b1;
        end_test("t12");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
